// File: rtl/manchester_tx_if.sv
// Bit-serial valid/ready stream feeding the Manchester transmitter.
// The source drives one bit per transfer; in_last flags the final bit of a frame.
interface manchester_tx_if;
  logic in_valid;
  logic in_data;
  logic in_last;
  logic in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/manchester_tx.sv
// Manchester load-modulation transmitter: SOC, data bits as D/E sequences, EOC,
// gating an external fc/16 subcarrier whose phase runs unbroken through the frame.
module manchester_tx #(
  parameter int BIT_TICKS = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  manchester_tx_if.slave    stream,
  output logic              sc_en,
  input  logic              subcarrier,
  output logic              lm_out,
  output logic              busy,
  output logic              underflow
);

  localparam int CW = $clog2(BIT_TICKS);
  localparam logic [CW-1:0] LAST_TICK = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] HALF_TICK = CW'(BIT_TICKS / 2);

  typedef enum logic [2:0] {IDLE, PRE, SOC, DATA, EOC} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            bit_reg, bit_next;
  logic            last_reg, last_next;
  logic            sc_en_reg, sc_en_next;
  logic            mod_reg, mod_next;
  logic            underflow_reg, underflow_next;
  logic            ready_c;
  logic            at_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      bit_reg       <= 1'b0;
      last_reg      <= 1'b0;
      sc_en_reg     <= 1'b0;
      mod_reg       <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      bit_reg       <= bit_next;
      last_reg      <= last_next;
      sc_en_reg     <= sc_en_next;
      mod_reg       <= mod_next;
      underflow_reg <= underflow_next;
    end
  end

  assign at_end = (count_reg == LAST_TICK);

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg + 1'b1;
    bit_next       = bit_reg;
    last_next      = last_reg;
    underflow_next = 1'b0;
    ready_c        = 1'b0;
    sc_en_next     = 1'b0;
    mod_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        ready_c    = 1'b1;
        count_next = '0;
        if (stream.in_valid) begin
          bit_next   = stream.in_data;
          last_next  = stream.in_last;
          state_next = PRE;
        end
      end
      PRE: begin
        count_next = '0;
        state_next = SOC;
      end
      SOC, DATA: begin
        if (at_end) begin
          // A one-bit frame opened in IDLE carries its bit straight into DATA;
          // otherwise every boundary pulls the next bit from the stream.
          if (last_reg) begin
            state_next = (state_reg == SOC) ? DATA : EOC;
          end else begin
            ready_c = 1'b1;
            if (stream.in_valid) begin
              bit_next   = stream.in_data;
              last_next  = stream.in_last;
              state_next = DATA;
            end else begin
              underflow_next = 1'b1;
              state_next     = EOC;
            end
          end
        end
      end
      EOC: begin
        if (at_end) begin
          count_next = '0;
          state_next = IDLE;
        end
      end
      default: begin
        count_next = '0;
        state_next = IDLE;
      end
    endcase

    // Modulate flag is registered one tick ahead so lm_out only ANDs in the live subcarrier.
    sc_en_next = (state_next == PRE) || (state_next == SOC) || (state_next == DATA);
    if (state_next == SOC)
      mod_next = (count_next < HALF_TICK);
    else if (state_next == DATA)
      mod_next = bit_next ? (count_next < HALF_TICK) : (count_next >= HALF_TICK);
  end

  assign stream.in_ready = ready_c;
  assign sc_en           = sc_en_reg;
  assign lm_out          = subcarrier & mod_reg;
  assign busy            = (state_reg != IDLE);
  assign underflow       = underflow_reg;

endmodule

// File: tb/tb_manchester_tx.sv
// Directed bench for manchester_tx with an fc/16 subcarrier generator in the loop.
module tb_manchester_tx;
  localparam int BT = 128;

  logic clk = 1'b0;
  logic rst_n;
  logic sc_en, subcarrier, lm_out, busy, underflow;
  logic [3:0] sc_cnt;
  int n_cmp = 0;
  int n_err = 0;
  int hs_count = 0;

  manchester_tx_if bus ();

  manchester_tx #(.BIT_TICKS(BT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stream     (bus),
    .sc_en      (sc_en),
    .subcarrier (subcarrier),
    .lm_out     (lm_out),
    .busy       (busy),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  // High on the first enabled edge, then toggles every 8 ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_cnt     <= 4'd0;
      subcarrier <= 1'b0;
    end else if (!sc_en) begin
      sc_cnt     <= 4'd0;
      subcarrier <= 1'b0;
    end else begin
      sc_cnt     <= sc_cnt + 4'd1;
      subcarrier <= ~sc_cnt[3];
    end
  end

  always @(posedge clk)
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) hs_count <= hs_count + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " in_ready"}, bus.in_ready, 1);
    chk({tag, " sc_en"}, sc_en, 0);
    chk({tag, " lm_out"}, lm_out, 0);
    $display("%s: idle", tag);
  endtask

  task automatic check_pre(input string tag);
    chk({tag, " pre busy"}, busy, 1);
    chk({tag, " pre sc_en"}, sc_en, 1);
    chk({tag, " pre lm_out"}, lm_out, 0);
    chk({tag, " pre in_ready"}, bus.in_ready, 0);
    $display("%s: PRE entered", tag);
  endtask

  task automatic idle_start(input logic d, input logic l, input string tag);
    chk({tag, " start in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(posedge clk); #1;
    check_pre(tag);
  endtask

  // kind 0 = D, 1 = E, 2 = F (EOC); next-transfer inputs are applied at tick 0.
  task automatic run_period(input int kind, input logic exp_bit, input logic ready_end,
                            input logic uf_first, input logic nv, input logic nd,
                            input logic nl, input string tag);
    int bad = 0;
    int first_on = 0;
    int second_on = 0;
    logic ph;
    logic dec;
    for (int t = 0; t < BT; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        bus.in_valid = nv;
        bus.in_data  = nd;
        bus.in_last  = nl;
        if (kind != 2) begin
          chk({tag, " subcarrier@tick0"}, subcarrier, 1);
        end else begin
          chk({tag, " underflow@eoc0"}, underflow, uf_first);
          chk({tag, " sc_en@eoc0"}, sc_en, 0);
        end
      end
      ph = (kind == 0) ? (t < BT/2) : ((kind == 1) ? (t >= BT/2) : 1'b0);
      if (lm_out !== (subcarrier & ph)) bad++;
      if (sc_en !== (kind != 2)) bad++;
      if (busy !== 1'b1) bad++;
      if (bus.in_ready !== ((t == BT-1) ? ready_end : 1'b0)) bad++;
      if ((t != 0 || kind != 2) && underflow !== 1'b0) bad++;
      if (lm_out === 1'b1) begin
        if (t < BT/2) first_on++;
        else second_on++;
      end
    end
    chk({tag, " tick errors"}, bad, 0);
    if (kind != 2) begin
      if (first_on > 0 && second_on == 0) dec = 1'b1;
      else if (first_on == 0 && second_on > 0) dec = 1'b0;
      else dec = 1'bx;
      chk({tag, " decoded bit"}, dec, exp_bit);
    end
    $display("%s: kind=%0d loaded first/second=%0d/%0d errors=%0d", tag, kind, first_on, second_on, bad);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] bits;
    int hs0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;
    bus.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset underflow", underflow, 0);
    check_idle("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("post-reset");

    // Single '1' bit, last=1; in_valid left high with junk to show it is ignored.
    idle_start(1'b1, 1'b1, "t1");
    run_period(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t1 soc");
    run_period(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t1 data");
    run_period(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "t1 eoc");
    @(posedge clk); #1;
    check_idle("t1 end");

    // Back-to-back: in_valid already high in the first IDLE cycle, one '0' bit.
    @(posedge clk); #1;
    check_pre("t6");
    run_period(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t6 soc");
    run_period(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t6 data");
    run_period(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t6 eoc");
    @(posedge clk); #1;
    check_idle("t6 end");

    // Byte 0xA5, LSB first, in_valid held high.
    bits = 8'hA5;
    hs0 = hs_count;
    idle_start(1'b1, 1'b0, "t2");
    run_period(0, 1'b1, 1'b1, 1'b0, 1'b1, bits[0], 1'b0, "t2 soc");
    for (int k = 0; k < 8; k++) begin
      run_period(bits[k] ? 0 : 1, bits[k], (k < 7), 1'b0, (k < 7),
                 (k < 7) ? bits[(k + 1) % 8] : 1'b0, (k == 6),
                 $sformatf("t2 bit%0d", k));
    end
    run_period(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t2 eoc");
    @(posedge clk); #1;
    check_idle("t2 end");
    chk("t2 handshakes", hs_count - hs0, 9);

    // Starvation before bit 3.
    idle_start(1'b1, 1'b0, "t3");
    run_period(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "t3 soc");
    run_period(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "t3 bit0");
    run_period(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "t3 bit1");
    run_period(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t3 bit2");
    run_period(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t3 eoc");
    @(posedge clk); #1;
    check_idle("t3 end");

    // Asynchronous reset at DATA tick 40.
    idle_start(1'b0, 1'b1, "t5");
    run_period(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t5 soc");
    for (int t = 0; t <= 40; t++) begin
      @(posedge clk); #1;
    end
    chk("t5 busy before reset", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 async sc_en", sc_en, 0);
    chk("t5 async lm_out", lm_out, 0);
    chk("t5 async busy", busy, 0);
    chk("t5 async underflow", underflow, 0);
    chk("t5 async in_ready", bus.in_ready, 1);
    $display("t5: reset applied mid-frame");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("t5 after reset");
    idle_start(1'b1, 1'b1, "t5b");
    run_period(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t5b soc");
    run_period(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t5b data");
    run_period(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t5b eoc");
    @(posedge clk); #1;
    check_idle("t5b end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
